// File: rtl/sequenciador_instrucoes_pkg.sv
// rtl/sequenciador_instrucoes_pkg.sv - ISA constants, field ranges and sequencer state encoding
package sequenciador_instrucoes_pkg;

  localparam int INSTR_W    = 9;
  localparam int ADDR_W_DEF = 8;

  localparam int OP_HI = 8;
  localparam int OP_LO = 6;
  localparam int RX_HI = 5;
  localparam int RX_LO = 3;
  localparam int RY_HI = 2;
  localparam int RY_LO = 0;

  localparam logic [2:0] OP_ALU0 = 3'b000;
  localparam logic [2:0] OP_ALU1 = 3'b001;
  localparam logic [2:0] OP_ALU2 = 3'b010;
  localparam logic [2:0] OP_ALU3 = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_HLT  = 3'b110;
  localparam logic [2:0] OP_REP  = 3'b111;

  localparam logic [1:0] STEP_FIRST = 2'b00;
  localparam logic [1:0] STEP_LAST  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_FETCH      = 3'd1,
    ST_FETCH_WAIT = 3'd2,
    ST_IMM        = 3'd3,
    ST_IMM_WAIT   = 3'd4,
    ST_EXEC       = 3'd5,
    ST_HALTED     = 3'd6
  } state_e;

  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OP_HI:OP_LO];
  endfunction

  function automatic logic [2:0] rx_of(input logic [INSTR_W-1:0] w);
    return w[RX_HI:RX_LO];
  endfunction

  function automatic logic [2:0] ry_of(input logic [INSTR_W-1:0] w);
    return w[RY_HI:RY_LO];
  endfunction

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ALU0) || (op == OP_ALU1) || (op == OP_ALU2) || (op == OP_ALU3);
  endfunction

  function automatic logic is_two_word(input logic [2:0] op);
    return (op == OP_LDI) && (op != OP_OUT) && (op != OP_REP);
  endfunction

endpackage

// File: rtl/sequenciador_instrucoes_contador_passos.sv
// rtl/sequenciador_instrucoes_contador_passos.sv - 2-bit step counter with clear and enable
module sequenciador_instrucoes_contador_passos
  import sequenciador_instrucoes_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q, cnt_d;

  // Clear wins over enable; 11 wraps naturally back to 00 on the last step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = STEP_FIRST;
    end else if (en_i) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= STEP_FIRST;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sequenciador_instrucoes.sv
// rtl/sequenciador_instrucoes.sv - instruction sequencer: PC, ROM fetch, LDI immediate, step counter, run/step/halt
module sequenciador_instrucoes
  import sequenciador_instrucoes_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = sequenciador_instrucoes_pkg::INSTR_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  input  logic               step_mode,
  input  logic               step_req,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] iin,
  output logic [INSTR_W-1:0] imm,
  output logic [1:0]         counter,
  output logic               busy,
  output logic               halted,
  output logic               done
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  iin_q, iin_d;
  logic [INSTR_W-1:0]  imm_q, imm_d;
  logic                done_q, done_d;
  logic [2:0]          opcode;
  logic                step_en;
  logic                step_clr;
  logic [1:0]          step_cnt;

  // Decode straight from the ROM word arriving this cycle, not the stale iin.
  assign opcode   = rom_data[INSTR_W-1 -: 3];
  assign step_en  = (state_q == ST_EXEC) && (!step_mode || step_req);
  assign step_clr = (state_q != ST_EXEC);

  sequenciador_instrucoes_contador_passos u_contador (
    .clk_i  (clock),
    .rst_ni (resetn),
    .clr_i  (step_clr),
    .en_i   (step_en),
    .cnt_o  (step_cnt)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      iin_q   <= '0;
      imm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iin_q   <= iin_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iin_d   = iin_q;
    imm_d   = imm_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: begin
        iin_d = rom_data;
        pc_d  = pc_q + ADDR_W'(1);
        if (opcode == OP_HLT) begin
          state_d = ST_HALTED;
          done_d  = 1'b1;
        end else if (is_two_word(opcode)) begin
          state_d = ST_IMM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_IMM: begin
        state_d = ST_IMM_WAIT;
      end
      ST_IMM_WAIT: begin
        imm_d   = rom_data;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // run is only consulted once the write step retires.
        if (step_en && (step_cnt == STEP_LAST)) begin
          state_d = run ? ST_FETCH : ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!run) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rom_addr = pc_q;
  assign iin      = iin_q;
  assign imm      = imm_q;
  assign counter  = step_cnt;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALTED);
  assign halted   = (state_q == ST_HALTED);
  assign done     = done_q;

endmodule
